disp_rd_buf: RTL

DISP_RD_BUF -- requirements
Module: disp_rd_buf

---
 rtl/disp_rd_buf.sv | 108 ++++++++++
 1 files changed

// File: rtl/disp_rd_buf.sv
// disp_rd_buf: frame-buffer read engine that refills a pixel FIFO with memory bursts for the display.
// Defining DISP_RD_UNDERFLOW_CNT_EN adds a saturating underflow event counter.
module disp_rd_buf #(
    parameter logic [20:0] FRAME_BASE      = 21'h0,
    parameter int          FRAME_WORDS     = 786432,
    parameter int          BURST_LEN       = 256,
    parameter int          FIFO_DEPTH      = 1024,
    parameter logic [15:0] UNDERFLOW_COLOR = 16'h0000
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic        video_vs,
    input  logic        data_req,
    output logic [15:0] pixel_data,
    output logic        mem_rd_req,
    output logic [20:0] mem_rd_addr,
    input  logic        mem_rd_ack,
    input  logic        mem_rd_valid,
    input  logic [15:0] mem_rd_data,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LEN);
    localparam int FW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} state_t;
    state_t state, state_nxt;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [BW-1:0] beat;
    logic [FW-1:0] fetched;
    logic          vs_q, fs, busy;
    logic          active, wr_en, rd_en, uf_ev, can_issue;

    // Words of a burst still in flight when a new frame starts are consumed but never stored.
    always_comb begin
        active    = state == FILL || state == RUN;
        wr_en     = mem_rd_valid && busy && active && !fs;
        rd_en     = data_req && state == RUN && !fs && count != '0;
        uf_ev     = data_req && !rd_en;
        can_issue = active && !fs && !busy && fetched < FW'(FRAME_WORDS) &&
                    count <= (AW+1)'(FIFO_DEPTH - BURST_LEN);
        state_nxt = fs ? FLUSH :
                    (state == FLUSH && !busy) ? FILL :
                    (state == FILL && (count >= (AW+1)'(BURST_LEN) || data_req)) ? RUN : state;
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n)
        if (!sys_rst_n) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_q        <= 1'b0;
            fs          <= 1'b0;
            busy        <= 1'b0;
            beat        <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= FRAME_BASE;
            fetched     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pixel_data  <= 16'h0000;
            underflow   <= 1'b0;
        end else begin
            vs_q <= video_vs;
            fs   <= vs_q && !video_vs;
            if (mem_rd_req && mem_rd_ack) busy <= 1'b1;
            else if (mem_rd_valid && busy && beat == BW'(BURST_LEN - 1)) busy <= 1'b0;
            if (mem_rd_valid && busy) beat <= beat + BW'(1);
            mem_rd_req <= !fs && (mem_rd_req ? !mem_rd_ack : can_issue);
            if (state == FLUSH) begin
                mem_rd_addr <= FRAME_BASE;
                fetched     <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
            end else begin
                if (mem_rd_req && mem_rd_ack) begin
                    mem_rd_addr <= mem_rd_addr + 21'(BURST_LEN);
                    fetched     <= fetched + FW'(BURST_LEN);
                end
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
            end
            if (rd_en) pixel_data <= mem[rd_ptr];
            else if (data_req) pixel_data <= UNDERFLOW_COLOR;
            underflow <= state == FLUSH ? 1'b0 : underflow | uf_ev;
        end
    end

    always_ff @(posedge pixel_clk)
        if (wr_en) mem[wr_ptr] <= mem_rd_data;

`ifdef DISP_RD_UNDERFLOW_CNT_EN
    always_ff @(posedge pixel_clk or negedge sys_rst_n)
        if (!sys_rst_n) underflow_cnt <= 16'h0000;
        else if (uf_ev && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
`else
    assign underflow_cnt = 16'h0000;
`endif

endmodule
